// File: rtl/byte_ram_responder.sv
// byte_ram_responder
//   Responder end of the LSB byte-wide memory port. Byte-addressed RAM with a
//   one-cycle registered read, single-byte writes, and an I/O window above
//   IO_BASE holding a TX byte FIFO drained over a valid/ready handshake.
//     IO_BASE+0 : TX data (write pushes a byte, read returns 0)
//     IO_BASE+4 : status {6'b0, io_overflow, io_buffer_full}; with SIM_HALT_EN
//                 defined, any write here raises the sticky sim_halt request.
//   Optional feature macro: SIM_HALT_EN.
//   Reset is synchronous and active-low; RAM contents survive reset.

module byte_ram_responder #(
   parameter int unsigned ADDR_W     = 17,
   parameter logic [31:0] IO_BASE    = 32'h0003_0000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ram_addr,
   input  logic        ram_writing,
   input  logic [7:0]  ram_data,
   output logic [7:0]  ram_loaded_data,
   output logic [7:0]  io_tx_data,
   output logic        io_tx_valid,
   input  logic        io_tx_ready,
   output logic        io_buffer_full,
   output logic        io_overflow,
   output logic        sim_halt
);

   localparam int unsigned RAM_BYTES  = 1 << ADDR_W;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = (PTR_W)'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [7:0] mem_q  [RAM_BYTES];
   logic [7:0] fifo_q [FIFO_DEPTH];

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   logic [7:0]       rdata_q,    rdata_d;
   logic [PTR_W-1:0] head_q,     head_d;
   logic [PTR_W-1:0] tail_q,     tail_d;
   logic [PTR_W:0]   count_q,    count_d;
   logic             overflow_q, overflow_d;

   // ---------------------------------------------------------------------
   // Address decode (full 32-bit compare; RAM index aliases upper bits)
   // ---------------------------------------------------------------------
   logic              is_ram;
   logic              is_tx;
   logic              is_stat;
   logic [ADDR_W-1:0] ram_idx;

   assign is_ram  = (ram_addr < IO_BASE);
   assign is_tx   = (ram_addr == IO_BASE);
   assign is_stat = (ram_addr == IO_BASE + 32'd4);
   assign ram_idx = ram_addr[ADDR_W-1:0];

   // ---------------------------------------------------------------------
   // FIFO handshake terms, all from registered state plus current inputs
   // ---------------------------------------------------------------------
   logic fifo_full;
   logic fifo_valid;
   logic pop;
   logic push_req;
   logic push;
   logic drop;

   assign fifo_valid = (count_q != '0);
   assign fifo_full  = (count_q == FULL_COUNT);
   assign pop        = fifo_valid && io_tx_ready;
   assign push_req   = ram_writing && is_tx;
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push       = push_req && (!fifo_full || pop);
   assign drop       = push_req && !push;

   // Next read byte: RAM array, status register, or zero for other I/O.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      rdata_d = 8'h00;
      if (is_ram) begin
         rdata_d = mem_q[ram_idx];
      end else if (is_stat) begin
         rdata_d = {6'b0, overflow_q, fifo_full};
      end
   end

   // Next FIFO pointers, occupancy and sticky overflow flag.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      if (pop) begin
         head_d = head_q + PTR_ONE;
      end
      if (push) begin
         tail_d = tail_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // RAM write port; the read above samples the old byte on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays carry no reset -- contents must survive reset and
      // a reset port would stop the array mapping onto RAM primitives.
      if (ram_writing && is_ram) begin
         mem_q[ram_idx] <= ram_data;
      end
   end

   // TX FIFO data slot write.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[tail_q] <= ram_data;
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of evaluation order.
      if (!rst) begin
         rdata_q    <= 8'h00;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef SIM_HALT_EN
   logic halt_q, halt_d;

   assign halt_d = halt_q | (ram_writing && is_stat);

   // Sticky halt request raised by any write to the status address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end

   assign sim_halt = halt_q;
`else
   assign sim_halt = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign ram_loaded_data = rdata_q;
   assign io_tx_data      = fifo_q[head_q];
   assign io_tx_valid     = fifo_valid;
   assign io_buffer_full  = fifo_full;
   assign io_overflow     = overflow_q;

endmodule

// File: tb/tb_byte_ram_responder.sv
// tb_byte_ram_responder
//   Drives directed scenarios followed by a random phase. A behavioural model
//   (associative-array RAM, byte queue for the TX FIFO) predicts every read
//   byte and handshake flag; a monitor on the falling edge compares the DUT
//   against those predictions.

module tb_byte_ram_responder;

   localparam logic [31:0] IO_BASE   = 32'h0003_0000;
   localparam int          RAM_BYTES = 1 << 17;
   localparam int          DEPTH     = 8;

   logic        clk;
   logic        rst;
   logic [31:0] ram_addr;
   logic        ram_writing;
   logic [7:0]  ram_data;
   logic [7:0]  ram_loaded_data;
   logic [7:0]  io_tx_data;
   logic        io_tx_valid;
   logic        io_tx_ready;
   logic        io_buffer_full;
   logic        io_overflow;
   logic        sim_halt;

   byte_ram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .ram_addr        (ram_addr),
      .ram_writing     (ram_writing),
      .ram_data        (ram_data),
      .ram_loaded_data (ram_loaded_data),
      .io_tx_data      (io_tx_data),
      .io_tx_valid     (io_tx_valid),
      .io_tx_ready     (io_tx_ready),
      .io_buffer_full  (io_buffer_full),
      .io_overflow     (io_overflow),
      .sim_halt        (sim_halt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------
   typedef struct {
      bit         known;
      logic [7:0] value;
   } rd_exp_t;

   int n_checks = 0;
   int n_pass   = 0;

   rd_exp_t    rd_exp[$];
   logic [7:0] ram_m[int];
   logic [7:0] fifo_m[$];
   bit         ovf_m  = 1'b0;
   bit         halt_m = 1'b0;

   task automatic check(input string name, input logic [7:0] actual,
                        input logic [7:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: applies the documented rules at each rising edge.
   always @(posedge clk) begin
      rd_exp_t e;
      bit      do_pop;
      bit      do_push;
      int      idx;
      if (!rst) begin
         e.known = 1'b1;
         e.value = 8'h00;
         rd_exp.push_back(e);
         fifo_m.delete();
         ovf_m  = 1'b0;
         halt_m = 1'b0;
      end else begin
         idx     = int'(ram_addr % RAM_BYTES);
         e.known = 1'b1;
         e.value = 8'h00;
         if (ram_addr < IO_BASE) begin
            e.known = ram_m.exists(idx);
            e.value = e.known ? ram_m[idx] : 8'h00;
         end else if (ram_addr == IO_BASE + 4) begin
            e.value = {6'b0, ovf_m, fifo_m.size() == DEPTH};
         end
         rd_exp.push_back(e);

         do_pop  = (fifo_m.size() != 0) && io_tx_ready;
         do_push = 1'b0;
         if (ram_writing) begin
            if (ram_addr < IO_BASE) begin
               ram_m[idx] = ram_data;
            end else if (ram_addr == IO_BASE) begin
               if (fifo_m.size() < DEPTH || do_pop) do_push = 1'b1;
               else ovf_m = 1'b1;
            end else if (ram_addr == IO_BASE + 4) begin
`ifdef SIM_HALT_EN
               halt_m = 1'b1;
`endif
            end
         end
         if (do_pop)  void'(fifo_m.pop_front());
         if (do_push) fifo_m.push_back(ram_data);
      end
   end

   // Monitor: compares DUT outputs against the model mid-cycle.
   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_exp.size() != 0) begin
         e = rd_exp.pop_front();
         if (e.known) check("ram_loaded_data", ram_loaded_data, e.value);
      end
      check("io_tx_valid",    {7'b0, io_tx_valid},    {7'b0, fifo_m.size() != 0});
      check("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, fifo_m.size() == DEPTH});
      check("io_overflow",    {7'b0, io_overflow},    {7'b0, ovf_m});
      check("sim_halt",       {7'b0, sim_halt},       {7'b0, halt_m});
      if (fifo_m.size() != 0) check("io_tx_data", io_tx_data, fifo_m[0]);
   end

   // One bus cycle: inputs change 1 time unit after the rising edge.
   task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic r);
      ram_addr    = a;
      ram_writing = w;
      ram_data    = d;
      io_tx_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sel;
      logic [31:0] addr_pool[8];
      addr_pool[0] = 32'h0000_0010;
      addr_pool[1] = 32'h0002_0010;   // aliases 0x10
      addr_pool[2] = 32'h0000_0020;
      addr_pool[3] = 32'h0001_FFFF;
      addr_pool[4] = 32'h0000_0003;
      addr_pool[5] = IO_BASE;
      addr_pool[6] = IO_BASE + 4;
      addr_pool[7] = IO_BASE + 8;

      rst = 1'b0;
      drive(32'h0, 1'b0, 8'h00, 1'b0);
      drive(32'h0, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;

      // 1: write then read back with one-cycle latency.
      drive(32'h10, 1'b1, 8'hA5, 1'b0);
      drive(32'h10, 1'b0, 8'h00, 1'b0);
      drive(32'h10, 1'b0, 8'h00, 1'b0);

      // 2: read-before-write on the same byte.
      drive(32'h20, 1'b1, 8'h11, 1'b0);
      drive(32'h20, 1'b1, 8'h3C, 1'b0);
      drive(32'h20, 1'b0, 8'h00, 1'b0);

      // 3: fill FIFO past depth, read status, then drain.
      for (int i = 1; i <= 9; i++) drive(IO_BASE, 1'b1, 8'(i), 1'b0);
      drive(IO_BASE + 4, 1'b0, 8'h00, 1'b0);
      drive(IO_BASE + 8, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 9; i++) drive(IO_BASE, 1'b0, 8'h00, 1'b1);

      // 4: steady push/pop with one byte resident.
      rst = 1'b0;
      drive(32'h0, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      drive(IO_BASE, 1'b1, 8'h41, 1'b0);
      for (int i = 0; i < 10; i++) drive(IO_BASE, 1'b1, 8'h42, 1'b1);
      drive(IO_BASE + 4, 1'b0, 8'h00, 1'b1);
      drive(IO_BASE, 1'b0, 8'h00, 1'b1);

      // 5: reset while bytes are pending; RAM survives.
      for (int i = 0; i < 5; i++) drive(IO_BASE, 1'b1, 8'hC0 + 8'(i), 1'b0);
      drive(IO_BASE, 1'b1, 8'hEE, 1'b1);
      drive(IO_BASE, 1'b0, 8'h00, 1'b1);
      rst = 1'b0;
      drive(32'h10, 1'b0, 8'h00, 1'b1);
      rst = 1'b1;
      drive(32'h10, 1'b0, 8'h00, 1'b1);
      drive(32'h10, 1'b0, 8'h00, 1'b1);

      // 6: halt request write, held afterwards.
      drive(IO_BASE + 4, 1'b1, 8'h5A, 1'b0);
      for (int i = 0; i < 3; i++) drive(32'h20, 1'b0, 8'h00, 1'b0);

      // Random phase.
      for (int n = 0; n < 2000; n++) begin
         sel = int'($urandom_range(0, 7));
         if (n == 1000) begin
            rst = 1'b0;
            drive(32'h0, 1'b0, 8'h00, 1'b0);
            rst = 1'b1;
         end
         drive(addr_pool[sel], 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 3) != 0));
      end

      drive(32'h10, 1'b0, 8'h00, 1'b1);
      drive(32'h10, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
